// File: rtl/conv_pkg.sv
// Shared FSM encoding and derived-geometry helpers for the conv pass scheduler.
package conv_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_ACCUM = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Conv units per half-row (two halves cover one output row).
  function automatic int unsigned calc_ncu(input int unsigned w, input int unsigned f);
    return (w - f + 1) / 2;
  endfunction

  function automatic int unsigned calc_rows(input int unsigned h, input int unsigned f);
    return h - f + 1;
  endfunction

  function automatic int unsigned calc_passes(input int unsigned h, input int unsigned f);
    return 2 * calc_rows(h, f);
  endfunction

  // MAC cycles per pass: one per kernel tap plus the bias/drain cycle.
  function automatic int unsigned calc_acc(input int unsigned d, input int unsigned f);
    return d * f * f + 1;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned passes);
    return (passes > 1) ? $clog2(passes) : 1;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned acc);
    return (acc > 1) ? $clog2(acc + 1) : 1;
  endfunction

endpackage

// File: rtl/conv_pass_counter.sv
// Half-row position tracker: slot address, output row and column half.
module conv_pass_counter
  import conv_pkg::*;
#(
  parameter int unsigned NCU    = 3,
  parameter int unsigned PASSES = 12,
  parameter int unsigned AW     = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [3:0]    row_number,
  output logic [3:0]    column,
  output logic [AW-1:0] wr_addr,
  output logic          last_pass
);

  // Step to the next half-row: left half -> right half -> next row's left half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_number <= 4'd0;
      column     <= 4'd0;
      wr_addr    <= '0;
    end else if (clear) begin
      row_number <= 4'd0;
      column     <= 4'd0;
      wr_addr    <= '0;
    end else if (advance) begin
      wr_addr <= wr_addr + AW'(1);
      if (column == 4'd0) begin
        column <= 4'(NCU);
      end else begin
        column     <= 4'd0;
        row_number <= row_number + 4'd1;
      end
    end
  end

  assign last_pass = (wr_addr == AW'(PASSES - 1));

endmodule

// File: rtl/conv_pass_scheduler.sv
// Sequences clear/accumulate/write passes over every half-row of a feature map.
module conv_pass_scheduler
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned D          = 1,
  parameter int unsigned H          = 8,
  parameter int unsigned W          = 8,
  parameter int unsigned F          = 3
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       start,
  input  logic                                       abort,
  input  logic                                       wr_ready,
  output logic [3:0]                                 row_number,
  output logic [3:0]                                 column,
  output logic                                       cu_reset,
  output logic                                       wr_en,
  output logic [calc_addr_w(calc_passes(H, F))-1:0]  wr_addr,
  output logic                                       busy,
  output logic                                       done
);

  localparam int unsigned NCU    = calc_ncu(W, F);
  localparam int unsigned PASSES = calc_passes(H, F);
  localparam int unsigned ACC    = calc_acc(D, F);
  localparam int unsigned AW     = calc_addr_w(PASSES);
  localparam int unsigned CW     = calc_cnt_w(ACC);

  // Pixel width only matters to the datapath; reject a degenerate setting early.
  if (DATA_WIDTH == 0) begin : g_dw_check
    $error("conv_pass_scheduler: DATA_WIDTH must be at least 1");
  end

  logic [2:0]    state, state_n;
  logic [CW-1:0] acc_cnt, acc_cnt_n;
  logic          pos_clear, pos_advance, last_pass;

  // State and accumulate-cycle counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      acc_cnt <= '0;
    end else begin
      state   <= state_n;
      acc_cnt <= acc_cnt_n;
    end
  end

  // Next-state logic; abort always wins over progress.
  always_comb begin
    state_n     = state;
    pos_advance = 1'b0;
    pos_clear   = 1'b0;
    acc_cnt_n   = '0;
    case (state)
      ST_IDLE:  if (start && !abort) state_n = ST_CLEAR;
      ST_CLEAR: state_n = abort ? ST_IDLE : ST_ACCUM;
      ST_ACCUM: begin
        if (abort)                          state_n = ST_IDLE;
        else if (acc_cnt == CW'(ACC - 1))   state_n = ST_WRITE;
      end
      ST_WRITE: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (wr_ready) begin
          if (last_pass) begin
            state_n = ST_DONE;
          end else begin
            state_n     = ST_CLEAR;
            pos_advance = 1'b1;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    pos_clear = (state_n == ST_IDLE);
    if (state == ST_ACCUM && state_n == ST_ACCUM) acc_cnt_n = acc_cnt + CW'(1);
  end

  // Status outputs decode straight from the state register.
  assign cu_reset = (state == ST_IDLE) || (state == ST_CLEAR) || (state == ST_DONE);
  assign busy     = (state != ST_IDLE);
  assign wr_en    = (state == ST_WRITE);
  assign done     = (state == ST_DONE);

  conv_pass_counter #(
    .NCU    (NCU),
    .PASSES (PASSES),
    .AW     (AW)
  ) u_pos (
    .clk        (clk),
    .reset      (reset),
    .clear      (pos_clear),
    .advance    (pos_advance),
    .row_number (row_number),
    .column     (column),
    .wr_addr    (wr_addr),
    .last_pass  (last_pass)
  );

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Self-checking bench: pass-level behavioural model compared every cycle.
module tb_conv_pass_scheduler;

  localparam int unsigned NCU    = 3;
  localparam int unsigned PASSES = 12;
  localparam int unsigned ACC    = 10;

  logic clk = 1'b0;
  logic reset, start, abort, wr_ready;
  logic [3:0] row_number, column;
  logic cu_reset, wr_en, busy, done;
  logic [3:0] wr_addr;

  logic start6;
  logic [3:0] row6, col6;
  logic cu_reset6, wr_en6, busy6, done6;
  logic [2:0] wr_addr6;

  always #5 clk = ~clk;

  conv_pass_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .wr_ready(wr_ready),
    .row_number(row_number), .column(column), .cu_reset(cu_reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  conv_pass_scheduler #(.DATA_WIDTH(8), .D(1), .H(6), .W(6), .F(3)) dut6 (
    .clk(clk), .reset(reset), .start(start6), .abort(1'b0), .wr_ready(1'b1),
    .row_number(row6), .column(col6), .cu_reset(cu_reset6), .wr_en(wr_en6),
    .wr_addr(wr_addr6), .busy(busy6), .done(done6)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: a run is a sequence of passes; each pass is one clear cycle,
  // ACC accumulate cycles, then write cycles until the buffer accepts.
  bit m_run, m_done;
  int m_p, m_off;
  int cyc, acc_cyc, last_lat;
  int n_wr, n_done, n_stall;
  int s_acc, s_wr, s_done, s_lat;

  always @(negedge clk) begin
    logic [31:0] e_cu, e_busy, e_wr, e_done, e_row, e_col, e_addr;
    cyc++;
    if (reset) begin
      m_run = 0; m_done = 0; m_p = 0; m_off = 0;
    end
    if (m_done) begin
      e_cu = 1; e_busy = 1; e_wr = 0; e_done = 1;
      e_row = m_p / 2; e_col = (m_p % 2) * NCU; e_addr = m_p;
    end else if (m_run) begin
      e_cu = (m_off == 0); e_busy = 1; e_wr = (m_off > ACC); e_done = 0;
      e_row = m_p / 2; e_col = (m_p % 2) * NCU; e_addr = m_p;
    end else begin
      e_cu = 1; e_busy = 0; e_wr = 0; e_done = 0; e_row = 0; e_col = 0; e_addr = 0;
    end
    chk("cu_reset", cu_reset, e_cu);
    chk("busy", busy, e_busy);
    chk("wr_en", wr_en, e_wr);
    chk("done", done, e_done);
    chk("row_number", row_number, e_row);
    chk("column", column, e_col);
    chk("wr_addr", wr_addr, e_addr);
    if (done === 1'b1) begin n_done++; last_lat = cyc - acc_cyc; end
    if (wr_en === 1'b1 && wr_ready && !abort && !reset) n_wr++;
    if (wr_en === 1'b1 && wr_addr == 4'd4) n_stall++;
    if (!reset) begin
      if (m_done) begin
        m_done = 0; m_p = 0;
      end else if (!m_run) begin
        if (start && !abort) begin m_run = 1; m_p = 0; m_off = 0; acc_cyc = cyc; end
      end else if (abort) begin
        m_run = 0; m_p = 0; m_off = 0;
      end else if (m_off <= ACC) begin
        m_off++;
      end else if (wr_ready) begin
        if (m_p == PASSES - 1) begin m_run = 0; m_done = 1; end
        else begin m_p++; m_off = 0; end
      end
    end
    // Small-geometry instance: 8 passes, columns alternate 0/2.
    if (start6) s_acc = cyc;
    if (wr_en6 === 1'b1) begin
      s_wr++;
      chk("col6", col6, (wr_addr6 % 2) * 2);
      chk("row6", row6, wr_addr6 / 2);
    end
    if (done6 === 1'b1) begin s_done++; s_lat = cyc - s_acc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    n_wr = 0; n_done = 0; n_stall = 0; last_lat = -1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while ((m_run || m_done) && k < budget) begin tick(); k++; end
    if (m_run || m_done) chk({name, "_timeout"}, 1, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1; start6 = 1'b0;
    s_wr = 0; s_done = 0; s_lat = -1; s_acc = 0;
    clear_stats();
    #1;
    chk("rst_cu_reset", cu_reset, 1);
    chk("rst_busy", busy, 0);
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Plain run, buffer always ready.
    clear_stats();
    pulse_start();
    wait_idle(400, "run1");
    tick();
    chk("run1_latency", last_lat, 145);
    chk("run1_writes", n_wr, 12);
    chk("run1_dones", n_done, 1);

    // Buffer stalls 5 cycles during pass 4.
    clear_stats();
    pulse_start();
    begin
      bit stalled;
      stalled = 0;
      for (int k = 0; k < 500 && (m_run || m_done); k++) begin
        if (!stalled && m_run && m_p == 4 && m_off == ACC + 1) begin
          wr_ready = 1'b0;
          repeat (5) tick();
          wr_ready = 1'b1;
          stalled = 1;
        end else begin
          tick();
        end
      end
    end
    wait_idle(10, "stall");
    tick();
    chk("stall_wr_cycles", n_stall, 6);
    chk("stall_latency", last_lat, 150);
    chk("stall_writes", n_wr, 12);

    // Abort in accumulate phase of pass 7.
    clear_stats();
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      if (m_run && m_p == 7 && m_off == 3) break;
      tick();
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_addr", wr_addr, 0);
    chk("abort_row", row_number, 0);
    repeat (200) tick();
    chk("abort_dones", n_done, 0);
    chk("abort_writes", n_wr, 7);

    // Start during pass 2 must be ignored.
    clear_stats();
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      if (m_run && m_p == 2 && m_off == 5) break;
      tick();
    end
    pulse_start();
    wait_idle(400, "restart");
    tick();
    chk("busy_start_writes", n_wr, 12);
    chk("busy_start_dones", n_done, 1);
    chk("busy_start_latency", last_lat, 145);

    // Reset during the write of pass 9, then a clean run.
    clear_stats();
    pulse_start();
    for (int k = 0; k < 500; k++) begin
      if (m_run && m_p == 9 && m_off > ACC) break;
      tick();
    end
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cu_reset", cu_reset, 1);
    chk("midrst_addr", wr_addr, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    clear_stats();
    pulse_start();
    wait_idle(400, "postrst");
    tick();
    chk("postrst_writes", n_wr, 12);
    chk("postrst_latency", last_lat, 145);

    // Randomised ready/abort/start traffic against the model.
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      for (int k = 0; k < 600 && (m_run || m_done); k++) begin
        wr_ready = ($urandom_range(0, 3) != 0);
        abort    = ($urandom_range(0, 399) == 0);
        start    = ($urandom_range(0, 19) == 0);
        tick();
      end
      start = 1'b0; abort = 1'b0; wr_ready = 1'b1;
      wait_idle(400, "random");
      tick();
    end

    // Smaller image on the second instance.
    start6 = 1'b1; tick(); start6 = 1'b0;
    for (int k = 0; k < 300 && s_done == 0; k++) tick();
    tick();
    chk("small_latency", s_lat, 97);
    chk("small_writes", s_wr, 8);
    chk("small_dones", s_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_pass_scheduler.md
CONV_PASS_SCHEDULER -- requirements
Module: conv_pass_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel/weight width (passed through to datapath; unused internally).
REQ-002 SHALL have parameter D, default 1, input depth.
REQ-003 SHALL have parameter H, default 8, image height.
REQ-004 SHALL have parameter W, default 8, image width.
REQ-005 SHALL have parameter F, default 3, kernel size; derived NCU=(W-F+1)/2, ROWS=H-F+1, PASSES=2*ROWS, ACC=D*F*F+1.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  request a full feature-map run.
REQ-009 SHALL have port abort  input  1  synchronous cancel of a run in progress.
REQ-010 SHALL have port wr_ready  input  1  output buffer can accept one half-row.
REQ-011 SHALL have port row_number  output  4  receptive-field row select for the RF selector.
REQ-012 SHALL have port column  output  4  half-row select, 0 or NCU.
REQ-013 SHALL have port cu_reset  output  1  clear for all conv units.
REQ-014 SHALL have port wr_en  output  1  half-row result valid for writing.
REQ-015 SHALL have port wr_addr  output  clog2(PASSES)  half-row slot index (0..PASSES-1).
REQ-016 SHALL have port busy  output  1  run in progress.
REQ-017 SHALL have port done  output  1  one-cycle pulse at run completion.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, ACCUM, WRITE, DONE.
REQ-019 IDLE: cu_reset=1, busy=0; start=1 -> CLEAR, row_number=0, column=0, wr_addr=0.
REQ-020 CLEAR: cu_reset=1 for exactly 1 cycle, busy=1 -> ACCUM.
REQ-021 ACCUM: cu_reset=0 for exactly ACC cycles (10 at defaults), cycle counter reset on entry -> WRITE.
REQ-022 WRITE: wr_en=1, cu_reset=0, wr_addr/row_number/column held stable until wr_ready=1; the cycle wr_en&wr_ready is the transfer.
REQ-023 On transfer with wr_addr<PASSES-1: wr_addr+1; if column=0 then column=NCU else column=0 and row_number+1; -> CLEAR.
REQ-024 On transfer with wr_addr=PASSES-1: -> DONE; counters keep final values.
REQ-025 DONE: done=1 for 1 cycle, busy=1, cu_reset=1 -> IDLE; row_number, column, wr_addr return to 0 on entry to IDLE.
REQ-026 Minimum pass latency with wr_ready tied high SHALL be ACC+2 cycles; full run PASSES*(ACC+2)+1 cycles from start accept to done (145 at defaults).
REQ-027 start while busy=1 SHALL be ignored; start and abort in the same IDLE cycle: abort wins, stay IDLE.
REQ-028 abort=1 in CLEAR/ACCUM/WRITE/DONE SHALL return to IDLE next cycle, no done pulse, no wr_en that cycle onward, counters zeroed.
REQ-029 wr_en SHALL never be asserted outside WRITE; done SHALL never coincide with wr_en.

Reset
REQ-030 On reset=1 (asynchronous): state=IDLE, row_number=0, column=0, wr_addr=0, counter=0, cu_reset=1, wr_en=0, busy=0, done=0.
REQ-031 Reset asserted mid-run SHALL discard the run; after deassertion the block waits in IDLE for a new start.

Structure
REQ-032 SHALL place the FSM state enum and derived-constant functions (NCU, ROWS, PASSES, ACC, address width) in shared package conv_pkg.
REQ-033 SHALL instantiate one sub-module conv_pass_counter holding the row_number/column/wr_addr advance logic; the FSM and ACCUM cycle counter stay in the top.
REQ-034 All outputs SHALL be registered or decoded directly from the state register; no combinational path from wr_ready to any output except via state.

Verification
REQ-035 Reset then start pulse, wr_ready=1 -> 12 wr_en pulses, wr_addr 0..11, (row,column) (0,0),(0,3),(1,0)..(5,3), done at cycle 145 after accept.
REQ-036 wr_ready held 0 for 5 cycles during pass 4 -> wr_en high 6 cycles, wr_addr=4, row_number=2, column=0 stable throughout; run ends 5 cycles late.
REQ-037 abort at ACCUM cycle 3 of pass 7 -> IDLE next cycle, counters 0, no done, no further wr_en.
REQ-038 start pulsed during ACCUM of pass 2 -> ignored; exactly 12 writes and one done.
REQ-039 reset asserted during WRITE of pass 9 -> outputs at reset values same cycle; new start gives a clean 12-pass run.
REQ-040 Parameters H=6,W=6,F=3 -> NCU=2, 8 passes, column toggles 0/2, done after 8*12+1=97 cycles.
